// File: rtl/data_sram_slave_pkg.sv
// Shared address map and helpers for the data-SRAM responder.
package data_sram_slave_pkg;

    localparam logic [15:0] MMIO_HI     = 16'hbfaf;
    localparam logic [15:0] TIMER_OFF   = 16'he000;
    localparam logic [15:0] LED_OFF     = 16'hf020;
    localparam logic [15:0] SCRATCH_OFF = 16'hf030;

    // Which registered source drives rdata.
    typedef enum logic {
        SRC_RAM,
        SRC_MMIO
    } rd_src_e;

    // Replace the bytes of old_v selected by we with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_slave_sram_bytewe.sv
// Byte-writable word RAM with a registered, read-first output. No reset on storage.
module sram_bytewe #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Read the old word, then update the enabled bytes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int unsigned b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_slave.sv
// Data-SRAM responder: word RAM plus timer / LED / scratch register window.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter logic [15:0] MMIO_HI = data_sram_slave_pkg::MMIO_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    logic        is_mmio;
    logic        ram_en;
    logic [31:0] ram_rdata;
    logic [15:0] off;

    logic [31:0] timer_q, timer_d;
    logic [15:0] led_q, led_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] mmio_rd_q, mmio_rd_d;
    rd_src_e     src_q, src_d;

    assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
    assign off     = data_sram_addr[15:0];
    // Reset-cycle accesses must not touch the array.
    assign ram_en  = data_sram_en && !is_mmio && !reset;

    sram_bytewe #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (data_sram_we),
        .addr_i (data_sram_addr[ADDR_W+1:2]),
        .wdata_i(data_sram_wdata),
        .rdata_o(ram_rdata)
    );

    // Register-window decode: read-first capture, byte-merged writes, timer advance.
    always_comb begin
        timer_d   = timer_q + 32'd1;
        led_d     = led_q;
        scratch_d = scratch_q;
        mmio_rd_d = mmio_rd_q;
        src_d     = src_q;
        if (data_sram_en) begin
            src_d = is_mmio ? SRC_MMIO : SRC_RAM;
            if (is_mmio) begin
                case (off)
                    TIMER_OFF: begin
                        mmio_rd_d = timer_q;
                        if (|data_sram_we) timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_we);
                    end
                    LED_OFF: begin
                        mmio_rd_d = {16'h0000, led_q};
                        if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
                        if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
                    end
                    SCRATCH_OFF: begin
                        mmio_rd_d = scratch_q;
                        scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
                    end
                    default: mmio_rd_d = '0;
                endcase
            end
        end
    end

    // State update; reset forces rdata to the zeroed register-window path.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            led_q     <= '0;
            scratch_q <= '0;
            mmio_rd_q <= '0;
            src_q     <= SRC_MMIO;
        end else begin
            timer_q   <= timer_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            mmio_rd_q <= mmio_rd_d;
            src_q     <= src_d;
        end
    end

    assign data_sram_rdata = (src_q == SRC_RAM) ? ram_rdata : mmio_rd_q;
    assign led             = led_q;

endmodule
